// File: rtl/period_meter_pkg.sv
// Shared state encoding and default sizing for the period meter.
// Imported by the top level; the edge detector is self-contained.
package period_meter_pkg;

  localparam int DEFAULT_CNT_W   = 24;
  localparam int DEFAULT_TIMEOUT = 1000000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_e;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus rise/fall detection.
// Reusable for buttons and external strobes.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // sync1/sync2 resolve metastability; prev holds the last synchronized level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous signal in I_CLK cycles,
// with a one-cycle valid pulse per input cycle and a sticky stall flag.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int          CNT_W   = DEFAULT_CNT_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_EN,
  input  logic             I_SIG,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic [CNT_W-1:0] O_HIGH,
  output logic             O_VALID,
  output logic             O_TIMEOUT,
  output logic             O_BUSY
);

  if ((TIMEOUT < 4) || (longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1))) begin : gTimeoutRange
    $error("period_meter: TIMEOUT must lie in 4 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sigRise;
  logic sigFall;

  sync_edge uSyncEdge (
    .clk_i  (I_CLK),
    .rst_i  (I_RST),
    .sig_i  (I_SIG),
    .rise_o (sigRise),
    .fall_o (sigFall)
  );

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hiCnt_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             timeout_q;
  logic             busy_q;

  // A rise always closes the running period and immediately opens the next one;
  // hiCnt_q is cleared on each rise so a lost falling edge reports zero high time.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hiCnt_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!I_EN) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= WAIT_RISE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
          WAIT_RISE: begin
            if (sigRise) begin
              state_q <= MEASURE;
              cnt_q   <= CNT_ONE;
              hiCnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
              timeout_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          MEASURE: begin
            if (sigRise) begin
              period_q  <= cnt_q;
              high_q    <= hiCnt_q;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
              cnt_q     <= CNT_ONE;
              hiCnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= WAIT_RISE;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
              if (sigFall) begin
                hiCnt_q <= cnt_q;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign O_PERIOD  = period_q;
  assign O_HIGH    = high_q;
  assign O_VALID   = valid_q;
  assign O_TIMEOUT = timeout_q;
  assign O_BUSY    = busy_q;

endmodule
